// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand per request.
// Optional two's-complement input, leading-zero blanking mask and a
// truncation flag when the magnitude does not fit in DIGITS decimal digits.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  input  logic                is_signed,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                neg,
  output logic                ovf,
  output logic [DIGITS-1:0]   lz_mask
);

  localparam int                ACC_W    = 4 * DIGITS;
  localparam int                CNT_W    = $clog2(BIN_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [DIGITS-1:0] LZ_RST   = ~DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FIN
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BIN_W-1:0]  sr_q;
  logic [ACC_W-1:0]  acc_q;
  logic              sign_q;
  logic              ovf_lat_q;

  logic              busy_q;
  logic              done_q;
  logic [ACC_W-1:0]  bcd_q;
  logic              neg_q;
  logic              ovf_q;
  logic [DIGITS-1:0] lz_q;

  logic              sign_d;
  logic [BIN_W-1:0]  mag_d;
  logic [ACC_W-1:0]  acc_adj_d;
  logic              ovf_lat_d;
  logic              zero_d;

  // Add 3 to every BCD digit that is 5 or more, so the next shift carries correctly.
  function automatic logic [ACC_W-1:0] add3_digits(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] res;
    logic [3:0]       dig;
    res = acc;
    for (int i = 0; i < DIGITS; i++) begin
      dig = acc[4*i +: 4];
      if (dig >= 4'd5) res[4*i +: 4] = dig + 4'd3;
    end
    return res;
  endfunction

  // Bit i set when digit i and every digit above it are zero; units digit never blanked.
  function automatic logic [DIGITS-1:0] lz_of(input logic [ACC_W-1:0] acc);
    logic [DIGITS-1:0] m;
    logic              upper_zero;
    m          = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (acc[4*i +: 4] == 4'd0);
      m[i]       = upper_zero;
    end
    return m;
  endfunction

  // Operand magnitude/sign at the accepting edge, and one adjust step of the accumulator.
  always_comb begin
    sign_d    = is_signed & bin[BIN_W-1];
    mag_d     = sign_d ? (~bin + BIN_W'(1)) : bin;
    acc_adj_d = add3_digits(acc_q);
    // A set top bit after adjustment is shifted out: the value has reached 10^DIGITS.
    ovf_lat_d = ovf_lat_q | acc_adj_d[ACC_W-1];
    // Zero magnitude: empty accumulator and nothing was ever shifted out of it.
    zero_d    = (acc_q == '0) & ~ovf_lat_q;
  end

  // Conversion datapath: load on accept, one adjust-and-shift per CONV cycle.
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_q      <= mag_d;
          acc_q     <= '0;
          sign_q    <= sign_d;
          ovf_lat_q <= 1'b0;
        end
      end
      CONV: begin
        acc_q     <= {acc_adj_d[ACC_W-2:0], sr_q[BIN_W-1]};
        sr_q      <= {sr_q[BIN_W-2:0], 1'b0};
        ovf_lat_q <= ovf_lat_d;
      end
      default: ;
    endcase
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      lz_q    <= LZ_RST;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CONV;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CONV: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= FIN;
        end
        FIN: begin
          bcd_q   <= acc_q;
          neg_q   <= sign_q & ~zero_d;
          ovf_q   <= ovf_lat_q;
          lz_q    <= lz_of(acc_q);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd     = bcd_q;
  assign neg     = neg_q;
  assign ovf     = ovf_q;
  assign lz_mask = lz_q;

endmodule
